// File: rtl/and_or_pipe.sv
// and_or_pipe: selectable two-level bitwise logic function (AND-OR, OR-AND,
// XOR of ANDs, AOI) over WIDTH-bit operands. The result travels through a
// chain of STAGES elastic valid/ready registers. The block also provides a
// per-result "any bit set" flag, a synchronous flush and a delivered-result
// counter.
module and_or_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic             any_hit,
   output logic [15:0]      result_cnt
);

   typedef enum logic [1:0] {
      MODE_AND_OR = 2'b00,
      MODE_OR_AND = 2'b01,
      MODE_XOR    = 2'b10,
      MODE_AOI    = 2'b11
   } mode_e;

   mode_e            mode_sel;
   logic [WIDTH-1:0] func_res;
   logic             func_hit;

   logic [STAGES-1:0] load;
   logic [STAGES-1:0] move;
   logic              accept;
   logic              deliver;

   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] v_d;
   logic [STAGES-1:0] hit_q;
   logic [STAGES-1:0] hit_d;
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  data_d [STAGES];
   logic [15:0]       cnt_q;
   logic [15:0]       cnt_d;

   assign mode_sel = mode_e'(mode);

   // Combinational logic function ahead of the first stage register
   always_comb begin
      func_res = '0;
      case (mode_sel)
         MODE_AND_OR: func_res = (a & b) | (c & d);
         MODE_OR_AND: func_res = (a | b) & (c | d);
         MODE_XOR:    func_res = (a & b) ^ (c & d);
         MODE_AOI:    func_res = ~((a & b) | (c & d));
         default:     func_res = '0;
      endcase
      func_hit = |func_res;
   end

   // Ready chain: evaluated from the output back towards the input, so a
   // stage can load whenever it is empty or its occupant moves on this cycle
   always_comb begin
      move = '0;
      load = '0;
      move[STAGES-1] = v_q[STAGES-1] & out_ready;
      load[STAGES-1] = ~v_q[STAGES-1] | move[STAGES-1];
      for (int k = STAGES - 2; k >= 0; k--) begin
         move[k] = v_q[k] & load[k+1];
         load[k] = ~v_q[k] | move[k];
      end
      in_ready = ~clr & load[0];
      accept   = in_valid & in_ready;
      deliver  = move[STAGES-1];
   end

   // Next-state of the stage registers; data only updates when a valid item
   // arrives so an emptied stage keeps its old (don't-care) contents
   always_comb begin
      v_d    = v_q;
      hit_d  = hit_q;
      data_d = data_q;
      if (load[0]) begin
         v_d[0] = accept;
         if (accept) begin
            data_d[0] = func_res;
            hit_d[0]  = func_hit;
         end
      end
      for (int k = 1; k < STAGES; k++) begin
         if (load[k]) begin
            v_d[k] = v_q[k-1];
            if (v_q[k-1]) begin
               data_d[k] = data_q[k-1];
               hit_d[k]  = hit_q[k-1];
            end
         end
      end
      if (clr) begin
         v_d = '0;
      end
   end

   // Delivered-result counter, wraps naturally; flush zeroes it and
   // suppresses a handshake completing in the same cycle
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (deliver) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q   <= '0;
         hit_q <= '0;
         cnt_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         v_q   <= v_d;
         hit_q <= hit_d;
         cnt_q <= cnt_d;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   assign out_valid  = v_q[STAGES-1];
   assign f          = data_q[STAGES-1];
   assign any_hit    = hit_q[STAGES-1];
   assign result_cnt = cnt_q;

endmodule

// File: tb/tb_and_or_pipe.sv
// tb_and_or_pipe: directed bench for and_or_pipe. Expected results are
// pushed to a scoreboard queue when an input is accepted and popped when the
// DUT completes an output handshake.
module tb_and_or_pipe;

   localparam int WIDTH  = 8;
   localparam int STAGES = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             clr;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a, b, c, d;
   logic [1:0]       mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] f;
   logic             any_hit;
   logic [15:0]      result_cnt;

   typedef struct {
      logic [WIDTH-1:0] f;
      logic             hit;
   } exp_t;

   exp_t             sb[$];
   int               n_checks = 0;
   int               n_fail = 0;
   int               cyc = 0;
   int               last_pop_cyc = 0;
   int               t_acc;
   int               idx;
   logic             last_acc;
   logic [15:0]      exp_cnt;
   logic             stall_prev;
   logic [WIDTH-1:0] held_f;
   logic             held_hit;

   and_or_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .c          (c),
      .d          (d),
      .mode       (mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .f          (f),
      .any_hit    (any_hit),
      .result_cnt (result_cnt)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   // Reference function written directly from the mode equations
   function automatic logic [WIDTH-1:0] golden(input logic [1:0] m,
                                               input logic [WIDTH-1:0] ia,
                                               input logic [WIDTH-1:0] ib,
                                               input logic [WIDTH-1:0] ic,
                                               input logic [WIDTH-1:0] id);
      case (m)
         2'b00:   return (ia & ib) | (ic & id);
         2'b01:   return (ia | ib) & (ic | id);
         2'b10:   return (ia & ib) ^ (ic & id);
         default: return ~((ia & ib) | (ic & id));
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic v, input logic [1:0] m,
                                 input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                 input logic [WIDTH-1:0] ic, input logic [WIDTH-1:0] id);
      in_valid = v;
      mode     = m;
      a        = ia;
      b        = ib;
      c        = ic;
      d        = id;
   endtask

   // Sampled at the falling edge: scoreboard push/pop, counter and stall checks
   task automatic check_output();
      exp_t e;
      last_acc = 1'b0;
      check("result_cnt", 64'(result_cnt), 64'(exp_cnt));
      if (clr) begin
         check("clr_blocks_ready", 64'(in_ready), 64'(0));
         sb.delete();
         stall_prev = 1'b0;
         exp_cnt    = '0;
      end else begin
         if (stall_prev) begin
            check("stall_valid", 64'(out_valid), 64'(1));
            check("stall_f", 64'(f), 64'(held_f));
            check("stall_hit", 64'(any_hit), 64'(held_hit));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_out", 64'(out_valid), 64'(0));
            end else begin
               e = sb.pop_front();
               check("f", 64'(f), 64'(e.f));
               check("any_hit", 64'(any_hit), 64'(e.hit));
               last_pop_cyc = cyc;
            end
            exp_cnt = exp_cnt + 16'd1;
         end
         if (in_valid && in_ready) begin
            e.f   = golden(mode, a, b, c, d);
            e.hit = |e.f;
            sb.push_back(e);
            last_acc = 1'b1;
         end
         stall_prev = out_valid && !out_ready;
         held_f     = f;
         held_hit   = any_hit;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      check_output();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain(input int max_cycles);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < max_cycles; i++) begin
         if (sb.size() == 0 && !out_valid) break;
         cycle();
      end
      check("drain_empty", 64'(sb.size()), 64'(0));
      check("drain_valid", 64'(out_valid), 64'(0));
   endtask

   task automatic flush_pulse();
      clr = 1'b1;
      cycle();
      clr = 1'b0;
   endtask

   initial begin
      rst        = 1'b0;
      clr        = 1'b0;
      out_ready  = 1'b0;
      exp_cnt    = '0;
      stall_prev = 1'b0;
      held_f     = '0;
      held_hit   = 1'b0;
      apply_stimulus(1'b0, 2'b00, '0, '0, '0, '0);

      // Reset state
      #23;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_f", 64'(f), 64'(0));
      check("rst_any_hit", 64'(any_hit), 64'(0));
      check("rst_cnt", 64'(result_cnt), 64'(0));
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'(1));

      // Legacy AND-OR and latency
      $display("[TB] legacy function and latency");
      out_ready = 1'b1;
      apply_stimulus(1'b1, 2'b00, 8'hFF, 8'h0F, 8'hF0, 8'h30);
      t_acc = cyc;
      cycle();
      check("t1_accepted", 64'(last_acc), 64'(1));
      apply_stimulus(1'b0, 2'b00, '0, '0, '0, '0);
      check("t1_early_valid", 64'(out_valid), 64'(0));
      check("t1_early_f", 64'(f), 64'(0));
      check("t1_early_hit", 64'(any_hit), 64'(0));
      for (int i = 0; i < 10 && sb.size() != 0; i++) cycle();
      check("t1_latency", 64'(last_pop_cyc - t_acc), 64'(STAGES));
      check("t1_cnt", 64'(result_cnt), 64'(1));

      // Other modes back to back; expected values come from the equations
      $display("[TB] modes 01/10/11");
      for (int m = 1; m < 4; m++) begin
         apply_stimulus(1'b1, 2'(m), 8'hA5, 8'h5A, 8'hFF, 8'h0F);
         for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_acc) break;
         end
      end
      drain(20);
      check("t2_cnt", 64'(result_cnt), 64'(4));

      // Backpressure
      $display("[TB] backpressure");
      flush_pulse();
      check("t3_cnt_zero", 64'(result_cnt), 64'(0));
      out_ready = 1'b0;
      idx = 0;
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(1'b1, (idx % 2 == 0) ? 2'b00 : 2'b10,
                        8'(idx * 37 + 5), 8'hFF, 8'h00, 8'(idx));
         cycle();
         if (last_acc) idx++;
      end
      check("t3_accepts_stalled", 64'(idx), 64'(STAGES));
      check("t3_in_ready_low", 64'(in_ready), 64'(0));
      out_ready = 1'b1;
      for (int i = 0; i < 50 && idx < 6; i++) begin
         apply_stimulus(1'b1, (idx % 2 == 0) ? 2'b00 : 2'b10,
                        8'(idx * 37 + 5), 8'hFF, 8'h00, 8'(idx));
         cycle();
         if (last_acc) idx++;
      end
      check("t3_all_accepted", 64'(idx), 64'(6));
      drain(20);
      check("t3_cnt", 64'(result_cnt), 64'(6));

      // Flush with two results in flight and a concurrent input
      $display("[TB] flush");
      out_ready = 1'b0;
      idx = 0;
      for (int i = 0; i < 10 && idx < 2; i++) begin
         apply_stimulus(1'b1, 2'b00, 8'(8'h31 + idx), 8'hFF, 8'h00, 8'h00);
         cycle();
         if (last_acc) idx++;
      end
      check("t4_in_flight", 64'(sb.size()), 64'(2));
      apply_stimulus(1'b1, 2'b00, 8'hEE, 8'hFF, 8'h00, 8'h00);
      flush_pulse();
      check("t4_valid_cleared", 64'(out_valid), 64'(0));
      check("t4_cnt_cleared", 64'(result_cnt), 64'(0));
      out_ready = 1'b1;
      apply_stimulus(1'b1, 2'b01, 8'h12, 8'h40, 8'h03, 8'h00);
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (last_acc) break;
      end
      check("t4_next_accepted", 64'(last_acc), 64'(1));
      drain(20);
      check("t4_cnt", 64'(result_cnt), 64'(1));

      // Counter wrap
      $display("[TB] counter wrap");
      flush_pulse();
      out_ready = 1'b1;
      for (int i = 0; i < 70000 && exp_cnt != 16'hFFFF; i++) begin
         apply_stimulus(1'b1, 2'(cyc), 8'(cyc), 8'(cyc >> 3), 8'(cyc * 5), 8'hC3);
         cycle();
      end
      check("t5_cnt_max", 64'(result_cnt), 64'(16'hFFFF));
      check("t5_out_valid", 64'(out_valid), 64'(1));
      cycle();
      check("t5_cnt_wrap", 64'(result_cnt), 64'(16'h0000));
      drain(20);

      // Asynchronous reset with a full pipeline
      $display("[TB] async reset");
      out_ready = 1'b0;
      for (int i = 0; i < 10 && in_ready; i++) begin
         apply_stimulus(1'b1, 2'b00, 8'(8'h81 + i), 8'hFF, 8'h00, 8'h00);
         cycle();
      end
      in_valid = 1'b0;
      check("t6_full_valid", 64'(out_valid), 64'(1));
      check("t6_full_hit", 64'(any_hit), 64'(1));
      #2;
      rst = 1'b0;
      #1;
      check("t6_rst_valid", 64'(out_valid), 64'(0));
      check("t6_rst_f", 64'(f), 64'(0));
      check("t6_rst_hit", 64'(any_hit), 64'(0));
      check("t6_rst_cnt", 64'(result_cnt), 64'(0));
      sb.delete();
      exp_cnt    = '0;
      stall_prev = 1'b0;
      #3;
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6_in_ready", 64'(in_ready), 64'(1));
      out_ready = 1'b1;
      apply_stimulus(1'b1, 2'b11, 8'h0F, 8'h0F, 8'h00, 8'h00);
      cycle();
      drain(20);
      check("t6_cnt", 64'(result_cnt), 64'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
